// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: active-high segment
// patterns ({g,f,e,d,c,b,a}), the dash marker code and the scan phase type.
package seg_pkg;

    localparam logic [3:0] CODE_DASH = 4'hF;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    // Active-low "everything off" value driven onto the seg pins.
    localparam logic [6:0] SEG_PINS_OFF = 7'h7F;

    typedef enum logic [1:0] {
        SCAN_IDLE = 2'd0,
        SCAN_DARK = 2'd1,
        SCAN_LIT  = 2'd2
    } scan_phase_e;

endpackage

// File: rtl/seg_scan_if.sv
// Signal bundle between the digit source and the seven-segment scanner,
// plus a debug view of the scan phase shown on the pins.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 8
);
    import seg_pkg::*;

    // en is a level, not a handshake: while high the scanner free-runs and
    // resamples digits_in/dp_in only at each frame start; low parks it dark.
    logic                      en;
    logic [4*NUM_DIGITS-1:0]   digits_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic                      blank_lz;

    logic [NUM_DIGITS-1:0]     an;
    logic [6:0]                seg;
    logic                      dp;
    logic                      frame_done;
    scan_phase_e               phase;

    modport master (
        output en, digits_in, dp_in, blank_lz,
        input  an, seg, dp, frame_done, phase
    );

    modport slave (
        input  en, digits_in, dp_in, blank_lz,
        output an, seg, dp, frame_done, phase
    );

endinterface

// File: rtl/seg_decode.sv
// Combinational BCD-to-seven-segment decoder, active-high pattern out.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] pattern_o
);

    always_comb begin
        pattern_o = SEG_BLANK;
        case (code_i)
            4'd0:      pattern_o = SEG_0;
            4'd1:      pattern_o = SEG_1;
            4'd2:      pattern_o = SEG_2;
            4'd3:      pattern_o = SEG_3;
            4'd4:      pattern_o = SEG_4;
            4'd5:      pattern_o = SEG_5;
            4'd6:      pattern_o = SEG_6;
            4'd7:      pattern_o = SEG_7;
            4'd8:      pattern_o = SEG_8;
            4'd9:      pattern_o = SEG_9;
            CODE_DASH: pattern_o = SEG_DASH;
            default:   pattern_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed common-anode seven-segment driver: per-frame input
// snapshot, per-slot ghosting blank, optional leading-zero suppression.
module seg_scan
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 50000,
    parameter int BLANK_CYC  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]            cnt_q, cnt_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]  snap_q, snap_d;
    logic [NUM_DIGITS-1:0]    snap_dp_q, snap_dp_d;

    logic [NUM_DIGITS-1:0]    an_q, an_d;
    logic [6:0]               seg_q, seg_d;
    logic                     dp_q, dp_d;
    logic                     frame_done_q, frame_done_d;
    scan_phase_e              phase_q, phase_d;

    logic                     frame_start;
    logic [3:0]               cur_code;
    logic [6:0]               cur_pattern;
    logic [NUM_DIGITS-1:0]    lz_mask;
    logic                     lz_run;

    // Counters and frame-start snapshot.
    always_comb begin
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        snap_dp_d   = snap_dp_q;
        frame_start = bus.en && (idx_q == '0) && (cnt_q == '0);

        if (!bus.en) begin
            cnt_d = '0;
            idx_d = '0;
        end else begin
            if (frame_start) begin
                snap_d    = bus.digits_in;
                snap_dp_d = bus.dp_in;
            end
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Walk down from the most significant digit; the run breaks at the
    // first non-zero code, so a dash also ends the suppression.
    always_comb begin
        lz_run  = bus.blank_lz;
        lz_mask = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            lz_run     = lz_run && (snap_q[4*k +: 4] == 4'd0);
            lz_mask[k] = lz_run;
        end
    end

    assign cur_code = snap_q[{idx_q, 2'b00} +: 4];

    seg_decode u_decode (
        .code_i    (cur_code),
        .pattern_o (cur_pattern)
    );

    // Output stage: phase decides lit vs dark, then pins follow.
    always_comb begin
        phase_d      = SCAN_IDLE;
        an_d         = '1;
        seg_d        = SEG_PINS_OFF;
        dp_d         = 1'b1;
        frame_done_d = 1'b0;

        if (bus.en) begin
            if ((cnt_q < CNT_BLANK) || lz_mask[idx_q]) begin
                phase_d = SCAN_DARK;
            end else begin
                phase_d = SCAN_LIT;
            end
            frame_done_d = (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);
        end

        if (phase_d == SCAN_LIT) begin
            an_d[idx_q] = 1'b0;
            seg_d       = ~cur_pattern;
            dp_d        = ~snap_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            snap_q       <= '1;
            snap_dp_q    <= '0;
            an_q         <= '1;
            seg_q        <= SEG_PINS_OFF;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
            phase_q      <= SCAN_IDLE;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            snap_dp_q    <= snap_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
            phase_q      <= phase_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = frame_done_q;
    assign bus.phase      = phase_q;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan (4 digits, 4-cycle slots, 1 dark cycle):
// a frame-position model predicts the pins every cycle, plus directed literals.
module tb_seg_scan;

    localparam int ND = 4;
    localparam int CD = 4;
    localparam int BC = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    seg_scan_if #(.NUM_DIGITS(ND)) bus ();

    seg_scan #(
        .NUM_DIGITS (ND),
        .CLK_DIV    (CD),
        .BLANK_CYC  (BC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic cmp_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] dec(input logic [3:0] code);
        case (code)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            4'hF: return 7'h40;
            default: return 7'h00;
        endcase
    endfunction

    // Model: position within the frame while enabled; predicts the pins
    // that appear after each rising edge.
    int         m_pos = 0;
    int         m_slot, m_off, m_msd;
    logic [15:0] m_snap = 16'hFFFF;
    logic [3:0]  m_dp   = 4'h0;
    logic [3:0]  exp_an  = 4'hF;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_dp  = 1'b1;
    logic        exp_fd  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos = 0; m_snap = 16'hFFFF; m_dp = 4'h0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
        end else if (!bus.en) begin
            m_pos = 0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
        end else begin
            if (m_pos == 0) begin
                m_snap = bus.digits_in;
                m_dp   = bus.dp_in;
            end
            m_slot = m_pos / CD;
            m_off  = m_pos % CD;
            m_msd  = 0;
            for (int k = 0; k < ND; k++)
                if (m_snap[4*k +: 4] != 4'd0) m_msd = k;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
            if (m_off >= BC && !(bus.blank_lz && m_slot > m_msd)) begin
                exp_an[m_slot] = 1'b0;
                exp_seg = ~dec(m_snap[4*m_slot +: 4]);
                exp_dp  = ~m_dp[m_slot];
            end
            exp_fd = (m_pos == ND*CD - 1);
            m_pos  = (m_pos + 1) % (ND*CD);
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_on) begin
            check("model_an",  32'(bus.an),         32'(exp_an));
            check("model_seg", 32'(bus.seg),        32'(exp_seg));
            check("model_dp",  32'(bus.dp),         32'(exp_dp));
            check("model_fd",  32'(bus.frame_done), 32'(exp_fd));
        end
    end

    task automatic restart(input logic [15:0] d, input logic [3:0] p, input logic lz);
        @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        bus.digits_in = d;
        bus.dp_in     = p;
        bus.blank_lz  = lz;
        bus.en        = 1'b1;
    endtask

    int fd_cnt;

    initial begin
        bus.en = 1'b0; bus.digits_in = '0; bus.dp_in = '0; bus.blank_lz = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_an",  32'(bus.an),         32'hF);
        check("rst_seg", 32'(bus.seg),        32'h7F);
        check("rst_dp",  32'(bus.dp),         32'h1);
        check("rst_fd",  32'(bus.frame_done), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_an",  32'(bus.an),  32'hF);
        check("idle_seg", 32'(bus.seg), 32'h7F);
        cmp_on = 1'b1;

        // Plain scan of 0042
        restart(16'h0042, 4'h0, 1'b0);
        fd_cnt = 0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (bus.frame_done) fd_cnt++;
            if (k == 1) check("s1_dark_an", 32'(bus.an), 32'hF);
            if (k == 2) begin
                check("s1_slot0_an",  32'(bus.an),  32'hE);
                check("s1_slot0_seg", 32'(bus.seg), 32'h24);
            end
            if (k == 6) begin
                check("s1_slot1_an",  32'(bus.an),  32'hD);
                check("s1_slot1_seg", 32'(bus.seg), 32'h19);
            end
            if (k == 10) begin
                check("s1_slot2_an",  32'(bus.an),  32'hB);
                check("s1_slot2_seg", 32'(bus.seg), 32'h40);
            end
            if (k == 16) check("s1_fd_pulse", 32'(bus.frame_done), 32'h1);
        end
        check("s1_fd_count", 32'(fd_cnt), 32'd2);

        // Leading-zero blanking of 0042
        restart(16'h0042, 4'h0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 2)  check("lz_slot0_seg", 32'(bus.seg), 32'h24);
            if (k == 6)  check("lz_slot1_an",  32'(bus.an),  32'hD);
            if (k == 10) check("lz_slot2_an",  32'(bus.an),  32'hF);
            if (k == 14) check("lz_slot3_an",  32'(bus.an),  32'hF);
        end

        // A dash stops suppression: 0F00
        restart(16'h0F00, 4'h0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 6)  check("dash_lz_slot1_seg", 32'(bus.seg), 32'h40);
            if (k == 10) check("dash_lz_slot2_seg", 32'(bus.seg), 32'h3F);
            if (k == 14) check("dash_lz_slot3_an",  32'(bus.an),  32'hF);
        end

        // All dashes with dp on digit 0
        restart(16'hFFFF, 4'b0001, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 2) begin
                check("dash_slot0_seg", 32'(bus.seg), 32'h3F);
                check("dash_slot0_dp",  32'(bus.dp),  32'h0);
            end
            if (k == 6)  check("dash_slot1_dp",  32'(bus.dp),  32'h1);
            if (k == 14) check("dash_slot3_seg", 32'(bus.seg), 32'h3F);
        end

        // Input change mid-frame waits for next frame
        restart(16'h0042, 4'h0, 1'b0);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 6) begin
                check("tear_slot1_seg", 32'(bus.seg), 32'h19);
                bus.digits_in = 16'h0099;
            end
            if (k == 7)  check("tear_hold_seg",  32'(bus.seg), 32'h19);
            if (k == 10) check("tear_slot2_seg", 32'(bus.seg), 32'h40);
            if (k == 18) check("next_slot0_seg", 32'(bus.seg), 32'h10);
            if (k == 22) check("next_slot1_seg", 32'(bus.seg), 32'h10);
        end

        // Drop enable in a lit cycle of slot 2
        restart(16'h0042, 4'h0, 1'b0);
        repeat (10) @(negedge clk);
        check("drop_pre_an", 32'(bus.an), 32'hB);
        bus.en = 1'b0;
        @(negedge clk);
        check("drop_an",  32'(bus.an),         32'hF);
        check("drop_seg", 32'(bus.seg),        32'h7F);
        check("drop_fd",  32'(bus.frame_done), 32'h0);
        bus.en = 1'b1;
        @(negedge clk);
        check("reen_dark_an", 32'(bus.an), 32'hF);
        @(negedge clk);
        check("reen_slot0_an",  32'(bus.an),  32'hE);
        check("reen_slot0_seg", 32'(bus.seg), 32'h24);

        // Asynchronous reset mid-slot
        restart(16'h0042, 4'h0, 1'b0);
        repeat (3) @(negedge clk);
        check("prerst_an", 32'(bus.an), 32'hE);
        #2 rst_n = 1'b0;
        #1;
        check("arst_an",  32'(bus.an),         32'hF);
        check("arst_seg", 32'(bus.seg),        32'h7F);
        check("arst_dp",  32'(bus.dp),         32'h1);
        check("arst_fd",  32'(bus.frame_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
